// File: rtl/ocm_arbiter.sv
// ocm_arbiter: memory-side responder for the per-core OCM request/stall interface.
// Picks one requesting core per transaction, performs a single access on a
// 1-cycle-latency single-port BRAM, then pulses a one-hot grant to release
// that core's stall. Sequence per transaction: IDLE -> ACCESS -> RESP.
// Optional build macro: OCM_ARB_FIXED_PRIO_EN selects fixed lowest-index
// priority and removes the round-robin pointer; otherwise round-robin.
module ocm_arbiter #(
   parameter int NUM_CORES = 2,
   parameter int ADDR_BITS = 12,
   parameter int DATA_W    = 32
) (
   input  logic                              clk,
   input  logic                              nrst,
   input  logic [NUM_CORES-1:0]              i_req,
   input  logic [NUM_CORES-1:0]              i_wr,
   input  logic [NUM_CORES*ADDR_BITS-1:0]    i_addr,
   input  logic [NUM_CORES*DATA_W-1:0]       i_wdata,
   input  logic [NUM_CORES*(DATA_W/8)-1:0]   i_be,
   output logic [NUM_CORES-1:0]              o_grant,
   output logic [DATA_W-1:0]                 o_rdata,
   output logic                              o_mem_en,
   output logic [DATA_W/8-1:0]               o_mem_we,
   output logic [ADDR_BITS-1:0]              o_mem_addr,
   output logic [DATA_W-1:0]                 o_mem_wdata,
   input  logic [DATA_W-1:0]                 i_mem_rdata
);

   localparam int BE_W  = DATA_W / 8;
   localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t               state;
   state_t               next_state;
   logic [IDX_W-1:0]     pick;
   logic [IDX_W-1:0]     winner;
   logic                 wr_lat;
   logic [DATA_W-1:0]    rdata_hold;
   logic                 sel_wr;
   logic [ADDR_BITS-1:0] sel_addr;
   logic [DATA_W-1:0]    sel_wdata;
   logic [BE_W-1:0]      sel_be;
   logic [NUM_CORES-1:0] grant_vec;
   logic                 start;

`ifdef OCM_ARB_FIXED_PRIO_EN
   // Fixed priority: the lowest-index requesting core wins.
   always_comb begin
      pick = '0;
      for (int j = NUM_CORES - 1; j >= 0; j--) begin
         pick = i_req[j] ? IDX_W'(j) : pick;
      end
   end
`else
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] pick_hi;
   logic [IDX_W-1:0] pick_lo;
   logic             hit_hi;

   // Round-robin: first requester at or above the pointer, else wrap to the lowest requester.
   always_comb begin
      pick_hi = '0;
      pick_lo = '0;
      hit_hi  = 1'b0;
      for (int j = NUM_CORES - 1; j >= 0; j--) begin
         pick_lo = i_req[j] ? IDX_W'(j) : pick_lo;
         pick_hi = (i_req[j] && (j >= int'(ptr))) ? IDX_W'(j) : pick_hi;
         hit_hi  = (i_req[j] && (j >= int'(ptr))) ? 1'b1 : hit_hi;
      end
      pick = hit_hi ? pick_hi : pick_lo;
   end

   // Priority pointer moves to the core after the one just granted, wrapping at the top.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         ptr <= '0;
      end else if (state == S_RESP) begin
         ptr <= (winner == IDX_W'(NUM_CORES - 1)) ? '0 : winner + IDX_W'(1);
      end else begin
         ptr <= ptr;
      end
   end
`endif

   // Route the picked core's request fields, and decode the latched winner to one-hot.
   always_comb begin
      sel_wr    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_be    = '0;
      grant_vec = '0;
      for (int j = 0; j < NUM_CORES; j++) begin
         sel_wr       = (pick == IDX_W'(j)) ? i_wr[j] : sel_wr;
         sel_addr     = (pick == IDX_W'(j)) ? i_addr[j*ADDR_BITS +: ADDR_BITS] : sel_addr;
         sel_wdata    = (pick == IDX_W'(j)) ? i_wdata[j*DATA_W +: DATA_W] : sel_wdata;
         sel_be       = (pick == IDX_W'(j)) ? i_be[j*BE_W +: BE_W] : sel_be;
         grant_vec[j] = (winner == IDX_W'(j));
      end
   end

   // Next-state logic; requests are only looked at in S_IDLE, unused encoding recovers to idle.
   always_comb begin
      next_state = S_IDLE;
      case (state)
         S_IDLE: begin
            if (|i_req) begin
               next_state = S_ACCESS;
            end else begin
               next_state = S_IDLE;
            end
         end
         S_ACCESS: next_state = S_RESP;
         S_RESP:   next_state = S_IDLE;
         default:  next_state = S_IDLE;
      endcase
   end

   assign start = (state == S_IDLE) && (next_state == S_ACCESS);

   // State, transaction latch and registered BRAM/grant outputs, precomputed from next state.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state       <= S_IDLE;
         winner      <= '0;
         wr_lat      <= 1'b0;
         rdata_hold  <= '0;
         o_grant     <= '0;
         o_mem_en    <= 1'b0;
         o_mem_we    <= '0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
      end else begin
         state    <= next_state;
         o_mem_en <= (next_state == S_ACCESS);
         o_grant  <= (next_state == S_RESP) ? grant_vec : '0;
         if (start) begin
            winner      <= pick;
            wr_lat      <= sel_wr;
            o_mem_addr  <= sel_addr;
            o_mem_wdata <= sel_wdata;
            o_mem_we    <= sel_wr ? sel_be : '0;
         end else begin
            o_mem_we    <= '0;
         end
         if ((state == S_RESP) && !wr_lat) begin
            rdata_hold <= i_mem_rdata;
         end else begin
            rdata_hold <= rdata_hold;
         end
      end
   end

   // Read data passes straight through in a read's grant cycle, otherwise the last read value holds.
   always_comb begin
      if ((state == S_RESP) && !wr_lat) begin
         o_rdata = i_mem_rdata;
      end else begin
         o_rdata = rdata_hold;
      end
   end

endmodule

// File: tb/tb_ocm_arbiter.sv
// Testbench for ocm_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model and a byte-enabled BRAM model.
module tb_ocm_arbiter;

   localparam int N  = 2;
   localparam int AW = 12;
   localparam int DW = 32;
   localparam int BW = DW / 8;

   logic            clk = 1'b0;
   logic            nrst;
   logic [N-1:0]    req;
   logic [N-1:0]    wr;
   logic [N*AW-1:0] addr;
   logic [N*DW-1:0] wdata;
   logic [N*BW-1:0] be;
   logic [N-1:0]    o_grant;
   logic [DW-1:0]   o_rdata;
   logic            o_mem_en;
   logic [BW-1:0]   o_mem_we;
   logic [AW-1:0]   o_mem_addr;
   logic [DW-1:0]   o_mem_wdata;
   logic [DW-1:0]   mem_rdata;

   logic            bd_we;
   logic [AW-1:0]   bd_addr;
   logic [DW-1:0]   bd_data;
   logic [DW-1:0]   mem     [0:4095];
   logic [DW-1:0]   ref_mem [0:4095];

   int vectors     = 0;
   int miscompares = 0;

   ocm_arbiter #(.NUM_CORES(N), .ADDR_BITS(AW), .DATA_W(DW)) dut (
      .clk(clk), .nrst(nrst), .i_req(req), .i_wr(wr), .i_addr(addr),
      .i_wdata(wdata), .i_be(be), .o_grant(o_grant), .o_rdata(o_rdata),
      .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata), .i_mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Single-port BRAM model: read-first, 1-cycle latency, byte write enables, plus a backdoor load.
   always @(posedge clk) begin
      if (bd_we) begin
         mem[bd_addr] <= bd_data;
      end else if (o_mem_en) begin
         mem_rdata <= mem[o_mem_addr];
         for (int b = 0; b < BW; b++) begin
            if (o_mem_we[b]) mem[o_mem_addr][b*8 +: 8] <= o_mem_wdata[b*8 +: 8];
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic backdoor(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      ref_mem[a] = d;
      step();
      bd_we = 1'b0;
   endtask

   task automatic set_req(input int c, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [BW-1:0] e);
      req[c] = 1'b1;
      wr[c]  = w;
      addr[c*AW +: AW]  = a;
      wdata[c*DW +: DW] = d;
      be[c*BW +: BW]    = e;
   endtask

   task automatic do_reset();
      nrst = 1'b0; req = '0; wr = '0;
      step(); step();
      nrst = 1'b1;
   endtask

   // Reference arbitration: first requester found scanning upward from the priority pointer.
   function automatic int model_pick(input logic [N-1:0] r, input int p);
      for (int i = 0; i < N; i++) begin
         int j;
         j = (p + i) % N;
         if (r[j]) return j;
      end
      return -1;
   endfunction

   task automatic test_reset();
      nrst = 1'b0; req = '0; wr = '0; addr = '0; wdata = '0; be = '0;
      step(); step();
      vectors++;
      if ({o_grant, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_rdata} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got grant=%b en=%b we=%b addr=%h wd=%h rd=%h, expected all zero",
                  o_grant, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_rdata);
      end
      nrst = 1'b1;
      step();
      vectors++;
      if ({o_grant, o_mem_en, o_mem_we} !== '0) begin
         miscompares++;
         $display("FAIL idle_after_reset: got grant=%b en=%b we=%b, expected zero", o_grant, o_mem_en, o_mem_we);
      end
   endtask

   task automatic test_single_read();
      backdoor(12'h010, 32'hDEADBEEF);
      set_req(0, 1'b0, 12'h010, 32'h0, 4'h0);
      step();
      vectors++;
      if (o_mem_en !== 1'b1 || o_mem_addr !== 12'h010 || o_mem_we !== 4'h0) begin
         miscompares++;
         $display("FAIL read_access: got en=%b addr=%h we=%b, expected 1 010 0000", o_mem_en, o_mem_addr, o_mem_we);
      end
      step();
      vectors++;
      if (o_grant !== 2'b01 || o_rdata !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL read_grant: got grant=%b rdata=%h, expected 01 deadbeef", o_grant, o_rdata);
      end
      req[0] = 1'b0;
      step();
      vectors++;
      if (o_grant !== 2'b00 || o_mem_en !== 1'b0) begin
         miscompares++;
         $display("FAIL read_after: got grant=%b en=%b, expected 00 0", o_grant, o_mem_en);
      end
   endtask

   task automatic test_byte_write();
      backdoor(12'h020, 32'hAABBCCDD);
      set_req(1, 1'b1, 12'h020, 32'h11223344, 4'b0011);
      step();
      vectors++;
      if (o_mem_en !== 1'b1 || o_mem_we !== 4'b0011 || o_mem_addr !== 12'h020 || o_mem_wdata !== 32'h11223344) begin
         miscompares++;
         $display("FAIL write_access: got en=%b we=%b addr=%h wd=%h, expected 1 0011 020 11223344",
                  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata);
      end
      step();
      vectors++;
      if (o_grant !== 2'b10) begin
         miscompares++;
         $display("FAIL write_grant: got %b expected 10", o_grant);
      end
      req[1] = 1'b0;
      step();
      set_req(0, 1'b0, 12'h020, 32'h0, 4'h0);
      step(); step();
      vectors++;
      if (o_grant !== 2'b01 || o_rdata !== 32'hAABB3344) begin
         miscompares++;
         $display("FAIL write_readback: got grant=%b rdata=%h, expected 01 aabb3344", o_grant, o_rdata);
      end
      req[0] = 1'b0;
      step();
   endtask

   task automatic test_contention();
      logic [N-1:0] exp_g;
      do_reset();
      set_req(0, 1'b0, 12'h010, 32'h0, 4'h0);
      set_req(1, 1'b0, 12'h020, 32'h0, 4'h0);
      for (int s = 1; s <= 12; s++) begin
         step();
         exp_g = '0;
         if (s % 3 == 2) begin
`ifdef OCM_ARB_FIXED_PRIO_EN
            exp_g[0] = 1'b1;
`else
            exp_g[(s / 3) % 2] = 1'b1;
`endif
         end
         vectors++;
         if (o_grant !== exp_g) begin
            miscompares++;
            $display("FAIL contention_cycle%0d: got grant=%b expected %b", s, o_grant, exp_g);
         end
      end
      req = '0;
      step(); step(); step();
   endtask

   task automatic test_stale_request();
      set_req(0, 1'b0, 12'h010, 32'h0, 4'h0);
      step(); step();
      vectors++;
      if (o_grant !== 2'b01) begin
         miscompares++;
         $display("FAIL stale_first_grant: got %b expected 01", o_grant);
      end
      step();
      req[0] = 1'b0;
      for (int s = 0; s < 5; s++) begin
         step();
         vectors++;
         if (o_grant !== 2'b00 || o_mem_en !== 1'b0) begin
            miscompares++;
            $display("FAIL stale_extra_access: got grant=%b en=%b expected 00 0", o_grant, o_mem_en);
         end
      end
   endtask

   task automatic test_reset_midop();
      set_req(0, 1'b1, 12'h030, 32'h55555555, 4'hF);
      step();
      vectors++;
      if (o_mem_en !== 1'b1) begin
         miscompares++;
         $display("FAIL midop_access: got en=%b expected 1", o_mem_en);
      end
      nrst = 1'b0; req = '0;
      step();
      vectors++;
      if ({o_grant, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_rdata} !== '0) begin
         miscompares++;
         $display("FAIL midop_reset_outputs: got grant=%b en=%b we=%b addr=%h wd=%h rd=%h expected zero",
                  o_grant, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_rdata);
      end
      nrst = 1'b1;
      step();
      vectors++;
      if (o_grant !== 2'b00) begin
         miscompares++;
         $display("FAIL midop_no_grant: got %b expected 00", o_grant);
      end
      set_req(1, 1'b0, 12'h010, 32'h0, 4'h0);
      step();
      step();
      vectors++;
      if (o_grant !== 2'b10 || o_rdata !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL midop_fresh_grant: got grant=%b rdata=%h expected 10 deadbeef", o_grant, o_rdata);
      end
      req = '0;
      step();
   endtask

   task automatic test_rdata_hold();
      set_req(0, 1'b1, 12'h040, 32'hCAFEF00D, 4'hF);
      step(); step();
      req[0] = 1'b0;
      step();
      set_req(0, 1'b0, 12'h040, 32'h0, 4'h0);
      step(); step();
      vectors++;
      if (o_rdata !== 32'hCAFEF00D) begin
         miscompares++;
         $display("FAIL hold_read: got %h expected cafef00d", o_rdata);
      end
      req[0] = 1'b0;
      step();
      set_req(1, 1'b1, 12'h041, 32'h12345678, 4'hF);
      for (int s = 0; s < 3; s++) begin
         step();
         vectors++;
         if (o_rdata !== 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL hold_during_write_c%0d: got %h expected cafef00d grant=%b", s, o_rdata, o_grant);
         end
         if (s == 1) req[1] = 1'b0;
      end
   endtask

   task automatic test_random();
      int            ptr_m;
      int            phase;
      int            w;
      logic          m_wr;
      logic [AW-1:0] m_addr;
      logic [DW-1:0] m_wdata;
      logic [BW-1:0] m_be;
      logic [DW-1:0] hold_m;
      logic [N-1:0]  exp_g;
      for (int a = 0; a < 16; a++) backdoor(12'h300 + 12'(a), $urandom);
      do_reset();
      ptr_m = 0; phase = 0; w = 0; hold_m = '0;
      m_wr = 1'b0; m_addr = '0; m_wdata = '0; m_be = '0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         for (int c = 0; c < N; c++) begin
            if (!req[c] && $urandom_range(0, 2) == 0)
               set_req(c, 1'($urandom_range(0, 1)), 12'h300 + 12'($urandom_range(0, 15)),
                       $urandom, 4'($urandom_range(0, 15)));
         end
         if (phase == 0) begin
            if (req != '0) begin
               w       = model_pick(req, ptr_m);
               m_wr    = wr[w];
               m_addr  = addr[w*AW +: AW];
               m_wdata = wdata[w*DW +: DW];
               m_be    = be[w*BW +: BW];
               phase   = 1;
            end
         end else if (phase == 1) begin
            phase = 2;
         end else begin
            phase = 0;
         end
         step();
         vectors++;
         if (o_mem_en !== (phase == 1) ||
             (phase == 1 && (o_mem_addr !== m_addr || o_mem_we !== (m_wr ? m_be : 4'h0) ||
                             (m_wr && o_mem_wdata !== m_wdata))) ||
             (phase != 1 && o_mem_we !== 4'h0)) begin
            miscompares++;
            $display("FAIL rand_mem_c%0d: got en=%b addr=%h we=%b wd=%h expected phase=%0d addr=%h wr=%b be=%b wd=%h",
                     cyc, o_mem_en, o_mem_addr, o_mem_we, o_mem_wdata, phase, m_addr, m_wr, m_be, m_wdata);
         end
         exp_g = '0;
         if (phase == 2) exp_g[w] = 1'b1;
         vectors++;
         if (o_grant !== exp_g) begin
            miscompares++;
            $display("FAIL rand_grant_c%0d: got %b expected %b", cyc, o_grant, exp_g);
         end
         if (phase == 2 && !m_wr) hold_m = ref_mem[m_addr];
         vectors++;
         if (o_rdata !== hold_m) begin
            miscompares++;
            $display("FAIL rand_rdata_c%0d: got %h expected %h", cyc, o_rdata, hold_m);
         end
         if (phase == 2) begin
            if (m_wr) begin
               for (int b = 0; b < BW; b++)
                  if (m_be[b]) ref_mem[m_addr][b*8 +: 8] = m_wdata[b*8 +: 8];
            end
`ifndef OCM_ARB_FIXED_PRIO_EN
            ptr_m = (w + 1) % N;
`endif
            req[w] = 1'b0;
         end
      end
      req = '0;
      step(); step(); step();
   endtask

   initial begin
      bd_we = 1'b0; bd_addr = '0; bd_data = '0;
      test_reset();
      test_single_read();
      test_byte_write();
      test_contention();
      test_stale_request();
      test_reset_midop();
      test_rdata_hold();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ocm_arbiter.md
Name: ocm_arbiter

Overview:
- Memory-side responder for the per-core OCM request/stall interface.
- Accepts level requests from NUM_CORES cores and selects one winner per transaction using round-robin.
- Performs the access on a single-port, 1-cycle-latency BRAM, then pulses a one-hot grant back to the winning core. That pulse releases the core's stall.
- Sits between the cores' OCM interfaces and the shared on-chip memory.

Parameters:
- NUM_CORES, 2, number of requesting cores (1..8).
- ADDR_BITS, 12, word address width into OCM.
- DATA_W, 32, data word width; byte enables are DATA_W/8 bits.

Ports:
- clk  in  1  clock.
- nrst  in  1  synchronous active-low reset.
- i_req  in  NUM_CORES  per-core request level; held high by the core until granted.
- i_wr  in  NUM_CORES  per-core 1=write, 0=read.
- i_addr  in  NUM_CORES*ADDR_BITS  per-core word address; core k occupies slice k.
- i_wdata  in  NUM_CORES*DATA_W  per-core write data.
- i_be  in  NUM_CORES*DATA_W/8  per-core byte enables (writes only).
- o_grant  out  NUM_CORES  one-hot, single-cycle completion pulse.
- o_rdata  out  DATA_W  read data; valid in the grant cycle of a read.
- o_mem_en  out  1  BRAM enable.
- o_mem_we  out  DATA_W/8  BRAM byte write enables.
- o_mem_addr  out  ADDR_BITS  BRAM address.
- o_mem_wdata  out  DATA_W  BRAM write data.
- i_mem_rdata  in  DATA_W  BRAM read data, valid one cycle after en.

Behaviour:
- States: S_IDLE, S_ACCESS, S_RESP. A 2-bit state register; unused encoding goes to S_IDLE.
- S_IDLE:
  - If any i_req bit is set, arbitrate, latch winner index, wr, addr, wdata and be, then go to S_ACCESS.
  - Otherwise stay in S_IDLE.
- S_ACCESS:
  - o_mem_en=1; o_mem_addr/o_mem_wdata come from the latched values.
  - o_mem_we = latched be if wr, else 0.
  - Always goes to S_RESP.
- S_RESP:
  - o_grant[winner]=1 for exactly this cycle.
  - For a read, o_rdata = i_mem_rdata.
  - Always returns to S_IDLE. Requests are never sampled in S_RESP, so the granted core's stale request is ignored.
- Latency: request seen in S_IDLE at cycle T → o_mem_en at T+1 → o_grant at T+2. Minimum spacing between grants is 3 cycles.
- o_rdata holds the last read value between read responses. Write responses leave o_rdata unchanged.
- Round-robin:
  - A priority pointer names the highest-priority core.
  - After each grant, the pointer becomes (winner+1) mod NUM_CORES.
  - The search wraps from NUM_CORES-1 to 0.
- Outputs are zero outside S_ACCESS/S_RESP: o_mem_en=0, o_mem_we=0, o_grant=0.
- Request deasserted after being latched (protocol violation): the access still completes and the grant still pulses.
- NUM_CORES=1: the arbiter degenerates to a pass-through with the same 3-cycle sequence.
- Reset values: state=S_IDLE, pointer=0, o_grant=0, o_rdata=0, o_mem_en=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0.
- Reset asserted mid-transaction: the transaction is abandoned, no grant is issued, and all registers take reset values on the next edge.

Optional Feature:
- OCM_ARB_FIXED_PRIO_EN defined:
  - Fixed priority; the lowest-index requesting core always wins.
  - The pointer register is removed.
- Not defined: round-robin as above.

Test Plan:
- Single read: core0 req, wr=0, addr=0x010, mem holds 0xDEADBEEF.
  - Response: o_mem_en at T+1 with addr 0x010.
  - o_grant=2'b01 and o_rdata=0xDEADBEEF at T+2.
  - o_grant=0 at T+3.
- Byte write: core1 req, wr=1, addr=0x020, wdata=0x11223344, be=4'b0011.
  - Response: o_mem_we=4'b0011 at T+1.
  - o_grant=2'b10 at T+2.
  - A subsequent read of 0x020 returns the upper 2 bytes unchanged and the low bytes as 0x3344.
- Contention: both cores request continuously from reset.
  - Grants go core0, core1, core0, core1 at 3-cycle spacing.
  - With OCM_ARB_FIXED_PRIO_EN, core0 wins every time.
- Stale request: core0 keeps req high during its S_RESP cycle, then drops it.
  - Exactly one grant is issued and no second access occurs.
- Reset mid-op: assert nrst=0 during S_ACCESS.
  - No o_grant pulse; all outputs 0 on the next cycle.
  - After release, a fresh core1 request is served with a grant at T+2.
- o_rdata hold: read 0xCAFEF00D, then write any value.
  - o_rdata remains 0xCAFEF00D through the write grant.
